// File: rtl/sega_pad_scanner.sv
// Sega MD 3/6-button DB9 pad scanner, NUM_PADS ports scanned in parallel; JOY_DEBOUNCE_EN adds two-frame agreement.
// Latency: one frame (8*PHASE_CYC + IDLE_CYC + 1 clks) plus 2 synchroniser clks.
// No backpressure: frame_o is a one-cycle strobe, results hold until the next commit.
module sega_pad_scanner #(
    parameter int NUM_PADS = 2,
    parameter int CLK_MHZ  = 84,
    parameter int PHASE_US = 3,
    parameter int IDLE_US  = 2000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PADS-1:0]     joy_p1_i,
    input  logic [NUM_PADS-1:0]     joy_p2_i,
    input  logic [NUM_PADS-1:0]     joy_p3_i,
    input  logic [NUM_PADS-1:0]     joy_p4_i,
    input  logic [NUM_PADS-1:0]     joy_p6_i,
    input  logic [NUM_PADS-1:0]     joy_p9_i,
    output logic                    joy_sel_o,
    output logic [12*NUM_PADS-1:0]  joy_o,
    output logic [NUM_PADS-1:0]     present_o,
    output logic [NUM_PADS-1:0]     six_btn_o,
    output logic                    frame_o
);

    localparam int PHASE_CYC = CLK_MHZ * PHASE_US;
    localparam int IDLE_CYC  = IDLE_US * CLK_MHZ;
    localparam int MAX_CYC   = (IDLE_CYC > PHASE_CYC) ? IDLE_CYC : PHASE_CYC;
    localparam int CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYC - 1);

    // STEPk is encoded as k+1, so an odd step has state[0]==0
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_STEP0 = 4'd1, ST_STEP1 = 4'd2, ST_STEP2 = 4'd3, ST_STEP3 = 4'd4,
        ST_STEP4 = 4'd5, ST_STEP5 = 4'd6, ST_STEP6 = 4'd7, ST_STEP7 = 4'd8,
        ST_COMMIT = 4'd9
    } state_t;

    state_t                        state;
    logic [CNT_W-1:0]              cnt;
    logic [6*NUM_PADS-1:0]         sync1, sync2;
    logic [NUM_PADS-1:0]           s_p1, s_p2, s_p3, s_p4, s_p6, s_p9;
    logic [NUM_PADS-1:0][11:0]     sh_btn;
    logic [NUM_PADS-1:0]           sh_pres, sh_six;
    logic [NUM_PADS-1:0][13:0]     raw;
    logic [NUM_PADS-1:0]           accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {joy_p9_i, joy_p6_i, joy_p4_i, joy_p3_i, joy_p2_i, joy_p1_i};
            sync2 <= sync1;
        end
    end

    assign s_p1 = sync2[0*NUM_PADS +: NUM_PADS];
    assign s_p2 = sync2[1*NUM_PADS +: NUM_PADS];
    assign s_p3 = sync2[2*NUM_PADS +: NUM_PADS];
    assign s_p4 = sync2[3*NUM_PADS +: NUM_PADS];
    assign s_p6 = sync2[4*NUM_PADS +: NUM_PADS];
    assign s_p9 = sync2[5*NUM_PADS +: NUM_PADS];

    always_comb begin
        for (int n = 0; n < NUM_PADS; n++) begin
            raw[n] = {sh_six[n], sh_pres[n], sh_btn[n]};
        end
    end

`ifdef JOY_DEBOUNCE_EN
    logic [NUM_PADS-1:0][13:0] prev_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_raw <= '0;
        end else if (state == ST_COMMIT) begin
            prev_raw <= raw;
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_PADS; n++) begin
            accept[n] = (raw[n] == prev_raw[n]);
        end
    end
`else
    assign accept = '1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            joy_sel_o <= 1'b1;
            joy_o     <= '0;
            present_o <= '0;
            six_btn_o <= '0;
            frame_o   <= 1'b0;
            sh_btn    <= '0;
            sh_pres   <= '0;
            sh_six    <= '0;
        end else begin
            frame_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cnt == IDLE_LAST) begin
                        state     <= ST_STEP0;
                        cnt       <= '0;
                        joy_sel_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    for (int n = 0; n < NUM_PADS; n++) begin
                        if (accept[n]) begin
                            joy_o[12*n +: 12] <= sh_pres[n] ? sh_btn[n] : 12'h000;
                            present_o[n]      <= sh_pres[n];
                            six_btn_o[n]      <= sh_pres[n] & sh_six[n];
                        end
                    end
                    frame_o   <= 1'b1;
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    joy_sel_o <= 1'b1;
                end
                default: begin
                    if (cnt == PHASE_LAST) begin
                        for (int n = 0; n < NUM_PADS; n++) begin
                            case (state)
                                ST_STEP0: sh_btn[n][5:0] <= {~s_p9[n], ~s_p6[n], ~s_p1[n],
                                                             ~s_p2[n], ~s_p3[n], ~s_p4[n]};
                                ST_STEP1: begin
                                    sh_pres[n]     <= ~s_p3[n] & ~s_p4[n];
                                    sh_btn[n][7:6] <= {~s_p9[n], ~s_p6[n]} & {2{~s_p3[n] & ~s_p4[n]}};
                                end
                                ST_STEP5: sh_six[n] <= ~(s_p1[n] | s_p2[n] | s_p3[n] | s_p4[n]);
                                ST_STEP6: sh_btn[n][11:8] <= {~s_p4[n], ~s_p3[n], ~s_p2[n], ~s_p1[n]}
                                                             & {4{sh_six[n]}};
                                default: ;
                            endcase
                        end
                        cnt <= '0;
                        if (state == ST_STEP7) begin
                            state     <= ST_COMMIT;
                            joy_sel_o <= 1'b1;
                        end else begin
                            state     <= state_t'(state + 4'd1);
                            joy_sel_o <= ~state[0];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sega_pad_scanner.sv
// Bench for sega_pad_scanner: behavioural 3/6-button pad models on each port, frame-level reference model.
module tb_sega_pad_scanner;

    localparam int NP = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NP-1:0] p1, p2, p3, p4, p6, p9;
    logic          joy_sel_o;
    logic [12*NP-1:0] joy_o;
    logic [NP-1:0] present_o, six_btn_o;
    logic          frame_o;

    sega_pad_scanner #(.NUM_PADS(NP), .CLK_MHZ(4), .PHASE_US(1), .IDLE_US(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .joy_p1_i(p1), .joy_p2_i(p2), .joy_p3_i(p3), .joy_p4_i(p4),
        .joy_p6_i(p6), .joy_p9_i(p9),
        .joy_sel_o(joy_sel_o), .joy_o(joy_o), .present_o(present_o),
        .six_btn_o(six_btn_o), .frame_o(frame_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // pad type: 0 unplugged, 1 three-button, 2 six-button; btn uses the joy_o bit order
    int          ptype [NP];
    logic [11:0] btn   [NP];
    logic [13:0] exp_o [NP];
    logic [13:0] prev_raw [NP];
    logic        glitch = 1'b0;

    // pad side: count select edges, a long high period resets the pad's phase
    int   phase = 0, hi_cnt = 0, eff_phase;
    logic prev_sel = 1'b1;
    assign eff_phase = phase + ((joy_sel_o != prev_sel) ? 1 : 0);

    always @(posedge clk) begin
        prev_sel <= joy_sel_o;
        hi_cnt   <= joy_sel_o ? hi_cnt + 1 : 0;
        if (joy_sel_o && hi_cnt >= 16) phase <= 0;
        else                           phase <= eff_phase;
    end

    function automatic logic [5:0] pad_pins(int ty, logic [11:0] b, logic sel, int ph);
        logic [5:0] p;  // {p9,p6,p4,p3,p2,p1}
        p = 6'h3F;
        if (ty != 0) begin
            if (sel) begin
                if (ty == 2 && ph == 6) p = {~b[5], ~b[4], ~b[11], ~b[10], ~b[9], ~b[8]};
                else                    p = {~b[5], ~b[4], ~b[0], ~b[1], ~b[2], ~b[3]};
            end else begin
                if (ty == 2 && ph == 5)      p = {~b[7], ~b[6], 4'b0000};
                else if (ty == 2 && ph == 7) p = {~b[7], ~b[6], 4'b1111};
                else                         p = {~b[7], ~b[6], 2'b00, ~b[2], ~b[3]};
            end
        end
        return p;
    endfunction

    always_comb begin
        p1 = '1; p2 = '1; p3 = '1; p4 = '1; p6 = '1; p9 = '1;
        for (int n = 0; n < NP; n++) begin
            {p9[n], p6[n], p4[n], p3[n], p2[n], p1[n]} = pad_pins(ptype[n], btn[n], joy_sel_o, eff_phase);
        end
        p1[0] = p1[0] & ~glitch;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // what one frame should report for a pad: {six, present, buttons}
    function automatic logic [13:0] frame_val(int n);
        case (ptype[n])
            1:       return {2'b01, 4'b0000, btn[n][7:0]};
            2:       return {2'b11, btn[n]};
            default: return 14'h0;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        for (int n = 0; n < NP; n++) begin
            chk({tag, " joy"},     32'(joy_o[12*n +: 12]), 32'(exp_o[n][11:0]));
            chk({tag, " present"}, 32'(present_o[n]),      32'(exp_o[n][12]));
            chk({tag, " six"},     32'(six_btn_o[n]),      32'(exp_o[n][13]));
        end
    endtask

    task automatic reset_model();
        for (int n = 0; n < NP; n++) begin
            exp_o[n]    = '0;
            prev_raw[n] = '0;
        end
    endtask

    // starts at the negedge of a frame's first idle cycle (t=0), ends at the next one
    task automatic run_frame(input int glitch_t, input int abort_t);
        logic [13:0] r;
        int k;
        for (int t = 1; t <= 73; t++) begin
            @(negedge clk);
            if (t == glitch_t)     glitch = 1'b1;
            if (t == glitch_t + 2) glitch = 1'b0;
            if (t == abort_t) begin
                rst_n = 1'b0;
                #1;
                chk("abort sel", 32'(joy_sel_o), 32'd1);
                chk("abort joy", 32'(joy_o), 32'd0);
                chk("abort joy hi", 32'(joy_o[47:32]), 32'd0);
                chk("abort present", 32'(present_o), 32'd0);
                chk("abort six", 32'(six_btn_o), 32'd0);
                chk("abort frame_o", 32'(frame_o), 32'd0);
                repeat (3) @(negedge clk);
                chk("in reset frame_o", 32'(frame_o), 32'd0);
                rst_n = 1'b1;
                reset_model();
                return;
            end
            if (t < 73) begin
                chk("frame_o quiet", 32'(frame_o), 32'd0);
                if (t < 40) chk("sel idle", 32'(joy_sel_o), 32'd1);
                else if (t < 72) begin
                    k = (t - 40) / 4;
                    chk("sel step", 32'(joy_sel_o), 32'((k % 2) == 0));
                end
                if (t == 60) check_outputs("hold");
            end else begin
                chk("frame_o pulse", 32'(frame_o), 32'd1);
                for (int n = 0; n < NP; n++) begin
                    r = frame_val(n);
                    if (n == 0 && glitch_t == 41) r[3] = 1'b1;
`ifdef JOY_DEBOUNCE_EN
                    if (r == prev_raw[n]) exp_o[n] = r;
                    prev_raw[n] = r;
`else
                    exp_o[n] = r;
`endif
                end
                check_outputs("commit");
            end
        end
    endtask

    initial begin
        for (int n = 0; n < NP; n++) begin
            ptype[n] = 0;
            btn[n]   = '0;
        end
        reset_model();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset sel", 32'(joy_sel_o), 32'd1);
        chk("reset joy", 32'(joy_o[31:0]), 32'd0);
        chk("reset present", 32'(present_o), 32'd0);
        chk("reset six", 32'(six_btn_o), 32'd0);
        chk("reset frame_o", 32'(frame_o), 32'd0);
        rst_n = 1'b1;
        run_frame(-1, -1);

        // 3-button pad on port 0, nothing on port 1
        ptype[0] = 1; btn[0] = 12'h018;
        run_frame(-1, -1); run_frame(-1, -1);
        chk("up+b joy0", 32'(joy_o[11:0]), 32'h018);
        chk("up+b present0", 32'(present_o[0]), 32'd1);
        chk("up+b six0", 32'(six_btn_o[0]), 32'd0);
        chk("empty joy1", 32'(joy_o[23:12]), 32'd0);
        chk("empty present1", 32'(present_o[1]), 32'd0);
        btn[0] = 12'h048;
        run_frame(-1, -1); run_frame(-1, -1);
        chk("up+a joy0", 32'(joy_o[11:0]), 32'h048);

        // 6-button pad: X + Mode + Start
        ptype[0] = 2; btn[0] = 12'hC80;
        run_frame(-1, -1); run_frame(-1, -1);
        chk("6btn joy0", 32'(joy_o[11:0]), 32'hC80);
        chk("6btn six0", 32'(six_btn_o[0]), 32'd1);

        // pin1 glitches: idle one is ignored, STEP0-sample one reaches U (unless debounced)
        ptype[0] = 1; btn[0] = 12'h000;
        run_frame(-1, -1); run_frame(-1, -1);
        run_frame(10, -1);
        chk("idle glitch joy0", 32'(joy_o[11:0]), 32'd0);
        run_frame(41, -1);
`ifdef JOY_DEBOUNCE_EN
        chk("step0 glitch joy0", 32'(joy_o[11:0]), 32'h000);
`else
        chk("step0 glitch joy0", 32'(joy_o[11:0]), 32'h008);
`endif
        run_frame(-1, -1);
        chk("after glitch joy0", 32'(joy_o[11:0]), 32'd0);

        // four pads, one distinct button each, then unplug pad 2
        for (int n = 0; n < NP; n++) begin
            ptype[n] = 1;
            btn[n]   = 12'(1 << n);
        end
        run_frame(-1, -1); run_frame(-1, -1);
        for (int n = 0; n < NP; n++) chk("single btn", 32'(joy_o[12*n +: 12]), 32'(1 << n));
        ptype[2] = 0;
        run_frame(-1, -1); run_frame(-1, -1);
        chk("unplug present2", 32'(present_o[2]), 32'd0);
        chk("unplug present3", 32'(present_o[3]), 32'd1);

        // reset during STEP3, then a clean frame
        run_frame(-1, 53);
        run_frame(-1, -1);

        for (int f = 0; f < 30; f++) begin
            for (int n = 0; n < NP; n++) begin
                ptype[n] = int'($urandom_range(0, 2));
                btn[n]   = 12'($urandom);
                if (btn[n][3] && btn[n][2]) btn[n][2] = 1'b0;
                if (btn[n][1] && btn[n][0]) btn[n][0] = 1'b0;
            end
            run_frame(-1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
